// File: rtl/cla_bist_ctrl.sv
// -----------------------------------------------------------------------------
// cla_bist_ctrl
// On-chip stimulus/response checker for an N-bit carry-lookahead adder.
// Drives a deterministic vector sequence into the adder, waits a fixed
// settling window, samples {cOut,sum} and compares it against a behavioural
// sum. Reports pass/fail, a saturating error count and the first failing
// vector index.
//
// Ports
//   clk            in   1   clock, rising edge
//   rst_n          in   1   synchronous active-low reset
//   start          in   1   run request, honoured only in IDLE or DONE
//   inA            out  N   operand A to adder (registered)
//   inB            out  N   operand B to adder (registered)
//   cIn            out  1   carry-in to adder (registered)
//   sum            in   N   adder sum
//   cOut           in   1   adder carry-out
//   busy           out  1   run in progress
//   done           out  1   run finished, held until next start or reset
//   pass           out  1   valid with done: no mismatches seen
//   err_count      out  8   mismatching vectors, saturating at 255
//   first_fail_idx out  8   index of first mismatch (0 when err_count==0)
// -----------------------------------------------------------------------------
module cla_bist_ctrl #(
    parameter int          N           = 4,
    parameter int          NUM_VECTORS = 16,
    parameter int          SETTLE      = 1,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [N-1:0] inA,
    output logic [N-1:0] inB,
    output logic         cIn,
    input  logic [N-1:0] sum,
    input  logic         cOut,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [7:0]   err_count,
    output logic [7:0]   first_fail_idx
);

    // An all-zero seed would lock the LFSR, so substitute the default.
    localparam logic [15:0] SEED_EFF    = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [7:0]  LAST_IDX    = 8'(NUM_VECTORS - 1);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    // Fibonacci LFSR, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    state_t         state_q, state_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [7:0]     vec_q, vec_d;
    logic [3:0]     settle_q, settle_d;
    logic [N-1:0]   ina_q, ina_d;
    logic [N-1:0]   inb_q, inb_d;
    logic           cin_q, cin_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           pass_q, pass_d;
    logic [7:0]     err_q, err_d;
    logic [7:0]     ffi_q, ffi_d;

    logic [15:0]    lfsr_adv;
    logic [N:0]     exp_sum;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        ina_d    = ina_q;
        inb_d    = inb_q;
        cin_d    = cin_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        ffi_d    = ffi_q;

        lfsr_adv = lfsr_step(lfsr_q);
        exp_sum  = {1'b0, ina_q} + {1'b0, inb_q} + {{N{1'b0}}, cin_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_DRIVE;
                    err_d    = 8'd0;
                    ffi_d    = 8'd0;
                    vec_d    = 8'd0;
                    settle_d = 4'd0;
                    lfsr_d   = SEED_EFF;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                end
            end

            S_DRIVE: begin
                // The two fixed corner vectors come first; the LFSR only
                // advances for the pseudo-random part of the sequence.
                if (vec_q == 8'd0) begin
                    ina_d = '0;
                    inb_d = '0;
                    cin_d = 1'b0;
                end else if (vec_q == 8'd1) begin
                    ina_d = '1;
                    inb_d = '1;
                    cin_d = 1'b1;
                end else begin
                    lfsr_d = lfsr_adv;
                    ina_d  = lfsr_adv[N-1:0];
                    inb_d  = lfsr_adv[2*N-1:N];
                    cin_d  = lfsr_adv[15];
                end
                settle_d = 4'd0;
                state_d  = S_WAIT;
            end

            S_WAIT: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = 4'd0;
                    state_d  = S_CHECK;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end

            S_CHECK: begin
                if ({cOut, sum} != exp_sum) begin
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    if (err_q == 8'd0) begin
                        ffi_d = vec_q;
                    end
                end
                if (vec_q == LAST_IDX) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // Uses this cycle's updated count so the last vector counts.
                    pass_d  = (err_d == 8'd0);
                end else begin
                    vec_d   = vec_q + 8'd1;
                    state_d = S_DRIVE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lfsr_q   <= SEED_EFF;
            vec_q    <= 8'd0;
            settle_q <= 4'd0;
            ina_q    <= '0;
            inb_q    <= '0;
            cin_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 8'd0;
            ffi_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            ina_q    <= ina_d;
            inb_q    <= inb_d;
            cin_q    <= cin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            ffi_q    <= ffi_d;
        end
    end

    assign inA            = ina_q;
    assign inB            = inb_q;
    assign cIn            = cin_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_idx = ffi_q;

endmodule
